// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply,
// restoring divide, one-cycle fast path for divide-by-zero and signed overflow.
module ex_muldiv #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1data,
  input  logic [XLEN-1:0] rs2data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_src, acc_nxt, prod;
  logic [XLEN-1:0]   b_reg, b_src;
  logic [2:0]        op_q, op_cur;
  logic              sign1_q, sign2_q, sign1_cur, sign2_cur;
  logic [4:0]        rd_q;

  logic              go, last;
  logic              sign1_in, sign2_in, div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag1, mag2, fast_res, calc_res, quo, rem;
  logic [XLEN:0]     mul_sum, trial;

  assign go   = (state == IDLE) && start && !flush;
  assign last = (state == CALC) && (cnt == CNT_W'(XLEN - 2));

  // Operand decode in IDLE: sign flags, magnitudes, fast-path detection.
  always_comb begin
    sign1_in = rs1data[XLEN-1] && (func3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    sign2_in = rs2data[XLEN-1] && (func3 inside {3'b001, 3'b100, 3'b110});
    mag1     = sign1_in ? -rs1data : rs1data;
    mag2     = sign2_in ? -rs2data : rs2data;
    div_zero = func3[2] && (rs2data == '0);
    div_ovf  = func3[2] && !func3[0] && (rs1data == MIN_NEG) && (rs2data == '1);
    special  = div_zero || div_ovf;
    if (div_zero) fast_res = func3[1] ? rs1data : '1;
    else          fast_res = func3[1] ? '0 : MIN_NEG;
  end

  // The first iteration runs on the fresh operands at the accepting edge,
  // so CALC needs only XLEN-1 cycles and the last one writes the result.
  always_comb begin
    if (state == IDLE) begin
      op_cur    = func3;
      sign1_cur = sign1_in;
      sign2_cur = sign2_in;
      acc_src   = {{XLEN{1'b0}}, func3[2] ? mag1 : mag2};
      b_src     = func3[2] ? mag2 : mag1;
    end else begin
      op_cur    = op_q;
      sign1_cur = sign1_q;
      sign2_cur = sign2_q;
      acc_src   = acc;
      b_src     = b_reg;
    end
  end

  always_comb begin
    mul_sum = {1'b0, acc_src[2*XLEN-1:XLEN]} + (acc_src[0] ? {1'b0, b_src} : '0);
    trial   = {acc_src[2*XLEN-1:XLEN], acc_src[XLEN-1]} - {1'b0, b_src};
    if (!op_cur[2])
      acc_nxt = {mul_sum, acc_src[XLEN-1:1]};
    else if (!trial[XLEN])
      acc_nxt = {trial[XLEN-1:0], acc_src[XLEN-2:0], 1'b1};
    else
      acc_nxt = {acc_src[2*XLEN-2:XLEN], acc_src[XLEN-1], acc_src[XLEN-2:0], 1'b0};

    prod = (sign1_cur ^ sign2_cur) ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    unique case (op_cur)
      3'b000:                 calc_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = (sign1_cur ^ sign2_cur) ? -quo : quo;
      default:                calc_res = sign1_cur ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = special ? DONE : CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
    stall = go || (state == CALC);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt     <= '0;
      acc     <= '0;
      b_reg   <= '0;
      op_q    <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      rd_q    <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else if (go) begin
      cnt     <= '0;
      acc     <= acc_nxt;
      b_reg   <= b_src;
      op_q    <= func3;
      sign1_q <= sign1_in;
      sign2_q <= sign2_in;
      rd_q    <= rd_in;
      if (special) begin
        result <= fast_res;
        rd_out <= rd_in;
      end
    end else if (state == CALC && !flush) begin
      acc <= acc_nxt;
      if (last) begin
        result <= calc_res;
        rd_out <= rd_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv at XLEN=32 and XLEN=8 against an
// arithmetic reference model of the RV32M operations.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        clr, flush;
  logic [2:0]  func3;
  logic [4:0]  rd_in;
  logic        start32, start8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;

  logic        busy32, stall32, valid32, busy8, stall8, valid8;
  logic [31:0] result32;
  logic [7:0]  result8;
  logic [4:0]  rd_out32, rd_out8;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  ex_muldiv #(.XLEN(32)) u_dut32 (
    .clk(clk), .clr(clr), .start(start32), .func3(func3), .rs1data(a32),
    .rs2data(b32), .rd_in(rd_in), .flush(flush), .busy(busy32),
    .stall(stall32), .valid(valid32), .result(result32), .rd_out(rd_out32)
  );

  ex_muldiv #(.XLEN(8)) u_dut8 (
    .clk(clk), .clr(clr), .start(start8), .func3(func3), .rs1data(a8),
    .rs2data(b8), .rd_in(rd_in), .flush(flush), .busy(busy8),
    .stall(stall8), .valid(valid8), .result(result8), .rd_out(rd_out8)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(input int w, input logic [63:0] u);
    return u[w-1] ? longint'(u) - (longint'(1) << w) : longint'(u);
  endfunction

  function automatic bit is_special(input int w, input logic [2:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    ua = {32'b0, a} & wmask(w);
    ub = {32'b0, b} & wmask(w);
    return f[2] && ((ub == 0) || (!f[0] && ua == (64'd1 << (w-1)) && ub == wmask(w)));
  endfunction

  function automatic logic [31:0] ref_res(input int w, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, up, m, r;
    longint      sa, sb, p;
    bit          ovf;
    m   = wmask(w);
    ua  = {32'b0, a} & m;
    ub  = {32'b0, b} & m;
    sa  = sext(w, ua);
    sb  = sext(w, ub);
    ovf = (sa == -(longint'(1) << (w-1))) && (sb == -1);
    case (f)
      3'd0: begin p = sa * sb; r = p & m; end
      3'd1: begin p = sa * sb; p = p >>> w; r = p & m; end
      3'd2: begin p = sa * longint'(ub); p = p >>> w; r = p & m; end
      3'd3: begin up = ua * ub; r = (up >> w) & m; end
      3'd4: if (ub == 0) r = m; else if (ovf) r = ua; else begin p = sa / sb; r = p & m; end
      3'd5: r = (ub == 0) ? m : ua / ub;
      3'd6: if (ub == 0) r = ua; else if (ovf) r = 0; else begin p = sa % sb; r = p & m; end
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  // Drives one start pulse and measures the response; callers do the comparing.
  task automatic issue(input bit n8, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output int stalls, output logic stall_v,
                       output logic [31:0] res, output logic [4:0] rdo);
    @(posedge clk); #1;
    func3 = f; rd_in = rd;
    if (n8) begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin start32 = 1'b1; a32 = a; b32 = b; end
    @(negedge clk);
    stalls = (n8 ? stall8 : stall32) ? 1 : 0;
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    lat = -1; stall_v = 1'bx; res = 'x; rdo = 'x;
    for (int n = 1; n <= 80 && lat < 0; n++) begin
      @(negedge clk);
      if (n8 ? valid8 : valid32) begin
        lat = n;
        stall_v = n8 ? stall8 : stall32;
        res = n8 ? {24'b0, result8} : result32;
        rdo = n8 ? rd_out8 : rd_out32;
      end else if (n8 ? stall8 : stall32) begin
        stalls++;
      end
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; flush = 1'b0; start32 = 1'b0; start8 = 1'b0;
    func3 = '0; rd_in = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy32); end
    checks++; if (valid32 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid32); end
    checks++; if (stall32 !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall32); end
    checks++; if (result32 !== 32'd0) begin failures++; $display("FAIL reset_result got=%h want=0", result32); end
    checks++; if (rd_out32 !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d want=0", rd_out32); end
    checks++; if (busy8 !== 1'b0 || result8 !== 8'd0) begin failures++; $display("FAIL reset_8 got=%b/%h want=0/00", busy8, result8); end
  endtask

  task automatic test_directed(input string name, input vec_t v[4], input int elat);
    int lat, st; logic sv; logic [31:0] res; logic [4:0] rdo, rd;
    for (int i = 0; i < 4; i++) begin
      rd = 5'($urandom_range(1, 31));
      issue(1'b0, v[i].f, v[i].a, v[i].b, rd, lat, st, sv, res, rdo);
      checks++; if (res !== v[i].e) begin failures++; $display("FAIL %s_res[%0d] got=%h want=%h", name, i, res, v[i].e); end
      checks++; if (rdo !== rd) begin failures++; $display("FAIL %s_rd[%0d] got=%0d want=%0d", name, i, rdo, rd); end
      checks++; if (lat != elat) begin failures++; $display("FAIL %s_latency[%0d] got=%0d want=%0d", name, i, lat, elat); end
      checks++; if (st != elat) begin failures++; $display("FAIL %s_stall_cycles[%0d] got=%0d want=%0d", name, i, st, elat); end
      checks++; if (sv !== 1'b0) begin failures++; $display("FAIL %s_stall_on_valid[%0d] got=%b want=0", name, i, sv); end
    end
  endtask

  task automatic test_mul_signs;
    vec_t v[4];
    v[0] = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    v[1] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    v[2] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    v[3] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    test_directed("mul", v, 32);
  endtask

  task automatic test_div_signs;
    vec_t v[4];
    v[0] = '{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD};
    v[1] = '{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF};
    v[2] = '{3'd5, 32'd100,      32'd7, 32'd14};
    v[3] = '{3'd7, 32'd100,      32'd7, 32'd2};
    test_directed("div", v, 32);
  endtask

  task automatic test_fast_path;
    vec_t v[4];
    v[0] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF};
    v[1] = '{3'd7, 32'd5,        32'd0,        32'd5};
    v[2] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    v[3] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
    test_directed("fast", v, 1);
  endtask

  task automatic test_flush;
    int lat, st, vcnt; logic sv; logic [31:0] res; logic [4:0] rdo;
    issue(1'b0, 3'd5, 32'd100, 32'd7, 5'd9, lat, st, sv, res, rdo);
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL flush_prior_res got=%h want=%h", res, 32'd14); end
    @(posedge clk); #1;
    func3 = 3'd5; a32 = 32'd1000; b32 = 32'd3; rd_in = 5'd17; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL flush_busy_before got=%b want=1", busy32); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL flush_busy_after got=%b want=0", busy32); end
    vcnt = 0;
    repeat (40) begin @(negedge clk); if (valid32) vcnt++; end
    checks++; if (vcnt != 0) begin failures++; $display("FAIL flush_no_valid got=%0d want=0", vcnt); end
    checks++; if (result32 !== 32'd14) begin failures++; $display("FAIL flush_result_held got=%h want=%h", result32, 32'd14); end
    checks++; if (rd_out32 !== 5'd9) begin failures++; $display("FAIL flush_rd_held got=%0d want=9", rd_out32); end
  endtask

  task automatic test_start_during_calc;
    int vcnt, first; logic [31:0] first_res;
    @(posedge clk); #1;
    func3 = 3'd0; a32 = 32'd1234; b32 = 32'd5678; rd_in = 5'd3; start32 = 1'b1;
    vcnt = 0; first = -1; first_res = 'x;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (valid32) begin
        vcnt++;
        if (first < 0) begin first = k; first_res = result32; end
        start32 = 1'b0;
      end
    end
    start32 = 1'b0;
    checks++; if (vcnt != 1) begin failures++; $display("FAIL hold_start_valid_count got=%0d want=1", vcnt); end
    checks++; if (first != 32) begin failures++; $display("FAIL hold_start_latency got=%0d want=32", first); end
    checks++; if (first_res !== 32'd7006652) begin failures++; $display("FAIL hold_start_res got=%h want=%h", first_res, 32'd7006652); end
  endtask

  task automatic test_flush_with_start;
    @(posedge clk); #1;
    func3 = 3'd1; a32 = 32'd3; b32 = 32'd3; start32 = 1'b1; flush = 1'b1;
    @(negedge clk);
    checks++; if (stall32 !== 1'b0) begin failures++; $display("FAIL flush_start_stall got=%b want=0", stall32); end
    @(posedge clk); #1 start32 = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b want=0", busy32); end
  endtask

  task automatic test_reset_mid_op;
    int lat, st; logic sv; logic [31:0] res; logic [4:0] rdo;
    @(posedge clk); #1;
    func3 = 3'd3; a32 = 32'hDEADBEEF; b32 = 32'h12345678; rd_in = 5'd21; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    repeat (5) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    checks++; if ({busy32, valid32, stall32} !== 3'b000) begin failures++; $display("FAIL clr_mid_flags got=%b want=000", {busy32, valid32, stall32}); end
    checks++; if (result32 !== 32'd0 || rd_out32 !== 5'd0) begin failures++; $display("FAIL clr_mid_regs got=%h/%0d want=0/0", result32, rd_out32); end
    issue(1'b0, 3'd0, 32'd3, 32'd4, 5'd6, lat, st, sv, res, rdo);
    checks++; if (res !== 32'd12) begin failures++; $display("FAIL clr_then_mul got=%h want=%h", res, 32'd12); end
    checks++; if (lat != 32) begin failures++; $display("FAIL clr_then_mul_latency got=%0d want=32", lat); end
  endtask

  task automatic test_width8;
    int lat, st; logic sv; logic [31:0] res; logic [4:0] rdo;
    vec_t v[3];
    v[0] = '{3'd0, 32'h7F, 32'h7F, 32'h01};
    v[1] = '{3'd3, 32'hFF, 32'hFF, 32'hFE};
    v[2] = '{3'd4, 32'h80, 32'hFF, 32'h80};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, v[i].f, v[i].a, v[i].b, 5'(i + 1), lat, st, sv, res, rdo);
      checks++; if (res !== v[i].e) begin failures++; $display("FAIL w8_res[%0d] got=%h want=%h", i, res, v[i].e); end
      checks++; if (lat != (is_special(8, v[i].f, v[i].a, v[i].b) ? 1 : 8)) begin
        failures++; $display("FAIL w8_latency[%0d] got=%0d want=%0d", i, lat, is_special(8, v[i].f, v[i].a, v[i].b) ? 1 : 8); end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Ops are issued back-to-back: each start lands in the cycle after DONE.
  task automatic test_random(input bit n8, input int count);
    int w, lat, st, elat; logic sv; logic [31:0] a, b, res, exp; logic [4:0] rdo, rd; logic [2:0] f;
    w = n8 ? 8 : 32;
    for (int i = 0; i < count; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      if (n8) begin a = a >> ($urandom_range(0, 1) * 24); b = {24'b0, b[7:0]}; a = {24'b0, a[7:0]}; end
      rd = 5'($urandom);
      issue(n8, f, a, b, rd, lat, st, sv, res, rdo);
      exp  = ref_res(w, f, a, b);
      elat = is_special(w, f, a, b) ? 1 : w;
      checks++; if (res !== exp) begin failures++; $display("FAIL rand%0d_res[%0d] f=%0d a=%h b=%h got=%h want=%h", w, i, f, a, b, res, exp); end
      checks++; if (rdo !== rd) begin failures++; $display("FAIL rand%0d_rd[%0d] got=%0d want=%0d", w, i, rdo, rd); end
      checks++; if (lat != elat || st != elat) begin failures++; $display("FAIL rand%0d_timing[%0d] lat=%0d stalls=%0d want=%0d", w, i, lat, st, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_signs();
    test_div_signs();
    test_fast_path();
    test_flush();
    test_start_during_calc();
    test_flush_with_start();
    test_reset_mid_op();
    test_width8();
    test_random(1'b0, 40);
    test_random(1'b1, 30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
